// File: rtl/deoxys_pkg.sv
// Shared definitions for the Deoxys-BC round-constant generator.
//
// Contents:
//   RCON_POLY        low byte of the GF(2^8) reduction polynomial 0x11b
//   DEOXYS_NUM_RCON  length of the full RCON sequence
//   rcon_state_e     two-state FSM encoding (IDLE / RUN)
//   rcon_fwd_step    multiply by x in GF(2^8)
//   rcon_inv_step    divide by x in GF(2^8) (exact inverse of rcon_fwd_step)
//   rcon_seed_inv    seed * x^n, used at elaboration to find the last
//                    forward constant, which is where the inverse walk starts
package deoxys_pkg;

  localparam logic [7:0] RCON_POLY       = 8'h1b;
  localparam int unsigned DEOXYS_NUM_RCON = 17;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } rcon_state_e;

  function automatic logic [7:0] rcon_fwd_step(input logic [7:0] v);
    return {v[6:0], 1'b0} ^ (v[7] ? RCON_POLY : 8'h00);
  endfunction

  // A forward step that reduced always leaves bit 0 set (RCON_POLY is odd),
  // and one that did not always leaves it clear, so bit 0 tells us whether
  // to undo the reduction before shifting back and restoring the old MSB.
  function automatic logic [7:0] rcon_inv_step(input logic [7:0] v);
    return v[0] ? (((v ^ RCON_POLY) >> 1) | 8'h80) : (v >> 1);
  endfunction

  function automatic logic [7:0] rcon_seed_inv(input logic [7:0] seed,
                                               input int unsigned n);
    logic [7:0] v;
    v = seed;
    for (int unsigned i = 0; i < n; i++) begin
      v = rcon_fwd_step(v);
    end
    return v;
  endfunction

endpackage

// File: rtl/deoxys_rcon_step.sv
// One direction-selectable LFSR step over GF(2^8).
//
// Ports:
//   dir_i  0 = forward (multiply by x), 1 = inverse (divide by x)
//   v_i    current constant
//   v_o    constant one step further along the selected direction
module deoxys_rcon_step
  import deoxys_pkg::*;
(
  input  logic       dir_i,
  input  logic [7:0] v_i,
  output logic [7:0] v_o
);

  assign v_o = dir_i ? rcon_inv_step(v_i) : rcon_fwd_step(v_i);

endmodule

// File: rtl/deoxys_rcon_gen.sv
// Sequential Deoxys-BC round-constant generator.
//
// Streams the RCON sequence forward (encryption) or backward (decryption)
// as RNDS_PER_CLK constants per beat on a valid/ready interface. The
// constants come from an LFSR over GF(2^8) rather than a lookup table.
//
// Ports:
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   start       begin a sequence (taken only while idle, see below)
//   dir         0 = forward, 1 = inverse; captured with start
//   ready_i     consumer accepts the current beat
//   valid_o     beat available (high throughout RUN)
//   constant_o  lane i at bits [8i+7:8i]; lanes past the end read 8'h00
//   cnt_o       beat index of the current beat
//   last_o      current beat is the final one
//   busy_o      sequence in progress
//   done_o      one-cycle pulse after the final beat is accepted
//
// Build option:
//   DEOXYS_RCON_RESTART_EN  when defined, start while busy aborts the
//                           running sequence and reloads from the new
//                           direction's seed; otherwise it is ignored.
module deoxys_rcon_gen
  import deoxys_pkg::*;
#(
  parameter int unsigned RNDS_PER_CLK = 1,
  parameter int unsigned NUM_CONST    = DEOXYS_NUM_RCON,
  parameter logic [7:0]  FWD_SEED     = 8'h2f
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      dir,
  input  logic                      ready_i,
  output logic                      valid_o,
  output logic [8*RNDS_PER_CLK-1:0] constant_o,
  output logic [5:0]                cnt_o,
  output logic                      last_o,
  output logic                      busy_o,
  output logic                      done_o
);

  localparam int unsigned BEATS    = (NUM_CONST + RNDS_PER_CLK - 1) / RNDS_PER_CLK;
  localparam logic [5:0]  LAST_CNT = 6'(BEATS - 1);
  // The inverse walk begins at the last forward constant.
  localparam logic [7:0]  INV_SEED = rcon_seed_inv(FWD_SEED, NUM_CONST - 1);

  rcon_state_e state_q, state_d;
  logic [7:0]  v_q, v_d;
  logic        dir_q, dir_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        done_q, done_d;

  logic        busy;
  logic        last_beat;
  logic [7:0]  seed_sel;

  // lane[i] is the state advanced by i steps; lane[RNDS_PER_CLK] is the
  // state for the next beat.
  logic [7:0]  lane [RNDS_PER_CLK+1];

  assign lane[0]   = v_q;
  assign busy      = (state_q == ST_RUN);
  assign last_beat = (cnt_q == LAST_CNT);
  assign seed_sel  = dir ? INV_SEED : FWD_SEED;

  for (genvar gi = 0; gi < RNDS_PER_CLK; gi++) begin : g_lane
    logic lane_live;

    deoxys_rcon_step u_step (
      .dir_i (dir_q),
      .v_i   (lane[gi]),
      .v_o   (lane[gi+1])
    );

    // Only the final beat can run past the end of the sequence; those
    // lanes are blanked. Everything is blanked while idle.
    assign lane_live = ((32'(cnt_q) * RNDS_PER_CLK + 32'(gi)) < NUM_CONST);
    assign constant_o[8*gi +: 8] = (busy && lane_live) ? lane[gi] : 8'h00;
  end

  always_comb begin
    state_d = state_q;
    v_d     = v_q;
    dir_d   = dir_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          dir_d   = dir;
          v_d     = seed_sel;
          cnt_d   = '0;
        end
      end
      ST_RUN: begin
`ifdef DEOXYS_RCON_RESTART_EN
        // Restart takes priority over any handshake in the same cycle, so
        // the aborted sequence never raises done.
        if (start) begin
          dir_d = dir;
          v_d   = seed_sel;
          cnt_d = '0;
        end else
`endif
        if (ready_i) begin
          if (last_beat) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b1;
          end else begin
            v_d   = lane[RNDS_PER_CLK];
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      v_q     <= FWD_SEED;
      dir_q   <= 1'b0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      v_q     <= v_d;
      dir_q   <= dir_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  assign valid_o = busy;
  assign busy_o  = busy;
  assign cnt_o   = cnt_q;
  assign last_o  = busy && last_beat;
  assign done_o  = done_q;

endmodule
